// File: rtl/conv_host_sequencer_pkg.sv
// Shared types and helpers for the convolutor host sequencer.
// Holds the FSM state encoding and the size legality / Z length helpers.
package conv_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    START,
    WAIT_DONE,
    RELEASE,
    READ_REQ,
    READ_WAIT,
    SEND,
    FINISH
  } host_state_t;

  // An operand length is legal when it is 1 .. 2**addr_w inclusive.
  function automatic logic size_legal(input int unsigned size, input int unsigned addr_w);
    return (size != 0) && (size <= (32'd1 << addr_w));
  endfunction

  // Full linear convolution length; callers size the result to Z_ADDR_W+1 bits.
  function automatic int unsigned z_len(input int unsigned size_x, input int unsigned size_y);
    return size_x + size_y - 1;
  endfunction

endpackage

// File: rtl/conv_host_sequencer_if.sv
// Bus bundle of the host sequencer: command, sample stream, operand memory,
// convolutor control, Z read port, result stream, status and debug state.
interface conv_host_sequencer_if
  import conv_host_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int Z_ADDR_W = 6,
  parameter int Z_W      = 16
);

  // Every valid/ready pair transfers exactly on a clock edge where both are
  // high; a source holds valid and its payload stable until that edge.
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [ADDR_W:0]     cmd_size_x_i;
  logic [ADDR_W:0]     cmd_size_y_i;
  logic                s_valid_i;
  logic                s_ready_o;
  logic [DATA_W-1:0]   s_data_i;
  logic                mem_we_o;
  logic                mem_sel_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [ADDR_W:0]     conv_size_x_o;
  logic [ADDR_W:0]     conv_size_y_o;
  logic                conv_start_o;
  logic                conv_done_i;
  logic                z_rd_o;
  logic [Z_ADDR_W-1:0] z_addr_o;
  logic [Z_W-1:0]      z_rdata_i;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [Z_W-1:0]      m_data_o;
  logic                m_last_o;
  logic                job_done_o;
  logic                err_size_o;
  logic                err_timeout_o;
  host_state_t         dbg_state;

  modport master (
    input  cmd_valid_i, cmd_size_x_i, cmd_size_y_i, s_valid_i, s_data_i,
           conv_done_i, z_rdata_i, m_ready_i,
    output cmd_ready_o, s_ready_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
           conv_size_x_o, conv_size_y_o, conv_start_o, z_rd_o, z_addr_o,
           m_valid_o, m_data_o, m_last_o, job_done_o, err_size_o, err_timeout_o,
           dbg_state
  );

  modport slave (
    output cmd_valid_i, cmd_size_x_i, cmd_size_y_i, s_valid_i, s_data_i,
           conv_done_i, z_rdata_i, m_ready_i,
    input  cmd_ready_o, s_ready_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
           conv_size_x_o, conv_size_y_o, conv_start_o, z_rd_o, z_addr_o,
           m_valid_o, m_data_o, m_last_o, job_done_o, err_size_o, err_timeout_o,
           dbg_state
  );

endinterface

// File: rtl/conv_host_sequencer_timeout.sv
// Watchdog counter for the WAIT_DONE state: cleared on entry, counts while
// enabled, flags the last allowed cycle. LIMIT of 0 never expires.
module conv_host_timeout #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (LIMIT != 0) && en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/conv_host_sequencer.sv
// Host-side sequencer for the convolutor: loads X/Y operands, runs the
// start/busy/done handshake with a watchdog, then streams Z results out.
module conv_host_sequencer
  import conv_host_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 5,
  parameter int Z_ADDR_W       = 6,
  parameter int Z_W            = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_host_sequencer_if.master bus
);

  localparam logic [ADDR_W:0]   ONE_S = 1;
  localparam logic [Z_ADDR_W:0] ONE_Z = 1;

  host_state_t state, state_n;

  logic [ADDR_W:0]     size_x_q, size_y_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [Z_ADDR_W:0]   zlen_q;
  logic [Z_ADDR_W-1:0] zaddr_q;
  logic                we_q, sel_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [Z_W-1:0]      mdata_q;
  logic                mlast_q;
  logic                err_size_q, err_to_q;
  logic                to_expire;

  logic            cmd_ok;
  logic [ADDR_W:0] cur_size;
  logic            load_last;
  logic            z_last;

  assign cmd_ok = size_legal(32'(bus.cmd_size_x_i), ADDR_W) &&
                  size_legal(32'(bus.cmd_size_y_i), ADDR_W);
  assign cur_size  = (state == LOAD_Y) ? size_y_q : size_x_q;
  assign load_last = ({1'b0, cnt_q} == (cur_size - ONE_S));
  assign z_last    = ({1'b0, zaddr_q} == (zlen_q - ONE_Z));

  conv_host_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == START),
    .en     (state == WAIT_DONE),
    .expire (to_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.cmd_valid_i && cmd_ok) state_n = LOAD_X;
      LOAD_X:    if (bus.s_valid_i && load_last) state_n = LOAD_Y;
      LOAD_Y:    if (bus.s_valid_i && load_last) state_n = START;
      START:     state_n = WAIT_DONE;
      // Done has priority over an expiring watchdog in the same cycle.
      WAIT_DONE: begin
        if (bus.conv_done_i)  state_n = RELEASE;
        else if (to_expire)   state_n = IDLE;
      end
      RELEASE:   state_n = READ_REQ;
      READ_REQ:  state_n = READ_WAIT;
      READ_WAIT: state_n = SEND;
      SEND:      if (bus.m_ready_i) state_n = mlast_q ? FINISH : READ_REQ;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_x_q   <= '0;
      size_y_q   <= '0;
      cnt_q      <= '0;
      zlen_q     <= '0;
      zaddr_q    <= '0;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      mdata_q    <= '0;
      mlast_q    <= 1'b0;
      err_size_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      err_size_q <= 1'b0;
      err_to_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            size_x_q   <= bus.cmd_size_x_i;
            size_y_q   <= bus.cmd_size_y_i;
            zlen_q     <= (Z_ADDR_W+1)'(z_len(32'(bus.cmd_size_x_i), 32'(bus.cmd_size_y_i)));
            cnt_q      <= '0;
            err_size_q <= !cmd_ok;
          end
        end
        LOAD_X, LOAD_Y: begin
          if (bus.s_valid_i) begin
            we_q    <= 1'b1;
            sel_q   <= (state == LOAD_Y);
            waddr_q <= cnt_q;
            wdata_q <= bus.s_data_i;
            cnt_q   <= load_last ? '0 : cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.conv_done_i && to_expire) err_to_q <= 1'b1;
        end
        RELEASE: zaddr_q <= '0;
        READ_WAIT: begin
          mdata_q <= bus.z_rdata_i;
          mlast_q <= z_last;
        end
        SEND: begin
          if (bus.m_ready_i && !mlast_q) zaddr_q <= zaddr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready_o   = (state == IDLE);
  assign bus.s_ready_o     = (state == LOAD_X) || (state == LOAD_Y);
  assign bus.mem_we_o      = we_q;
  assign bus.mem_sel_o     = sel_q;
  assign bus.mem_addr_o    = waddr_q;
  assign bus.mem_wdata_o   = wdata_q;
  assign bus.conv_size_x_o = size_x_q;
  assign bus.conv_size_y_o = size_y_q;
  assign bus.conv_start_o  = (state == WAIT_DONE);
  assign bus.z_rd_o        = (state == READ_REQ);
  assign bus.z_addr_o      = zaddr_q;
  assign bus.m_valid_o     = (state == SEND);
  assign bus.m_data_o      = mdata_q;
  assign bus.m_last_o      = mlast_q;
  assign bus.job_done_o    = (state == FINISH);
  assign bus.err_size_o    = err_size_q;
  assign bus.err_timeout_o = err_to_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_conv_host_sequencer.sv
// Self-checking bench for conv_host_sequencer with a behavioural convolutor
// and operand/Z memories; writes and result words are scoreboarded.
module tb_conv_host_sequencer;
  import conv_host_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int Z_ADDR_W = 6;
  localparam int Z_W = 16;
  localparam int TO_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_host_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_ADDR_W(Z_ADDR_W), .Z_W(Z_W)) bus ();

  conv_host_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .Z_ADDR_W(Z_ADDR_W), .Z_W(Z_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [Z_W:0]           exp_q[$];     // {last, data}
  logic [ADDR_W+DATA_W:0] exp_wr_q[$];  // {sel, addr, data}

  logic [DATA_W-1:0] xv[32];
  logic [DATA_W-1:0] yv[32];
  int sx, sy;

  // Behavioural convolutor: operand memories, Z memory, done after a delay.
  logic [DATA_W-1:0] xmem[32];
  logic [DATA_W-1:0] ymem[32];
  logic [Z_W-1:0]    zmem[64];
  int   done_delay = 0;
  int   mdl_cnt = 0;
  logic start_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      if (bus.mem_sel_o) ymem[bus.mem_addr_o] = bus.mem_wdata_o;
      else               xmem[bus.mem_addr_o] = bus.mem_wdata_o;
    end
    if (bus.conv_start_o && !start_prev) begin
      for (int k = 0; k < 64; k++) begin
        int acc;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
          if (i < int'(bus.conv_size_x_o) && (k - i) >= 0 && (k - i) < int'(bus.conv_size_y_o))
            acc += int'(xmem[i]) * int'(ymem[k-i]);
        end
        zmem[k] = Z_W'(acc);
      end
    end
    start_prev = bus.conv_start_o;
    if (bus.conv_start_o) begin
      mdl_cnt++;
      bus.conv_done_i = (done_delay > 0) && (mdl_cnt == done_delay);
    end else begin
      mdl_cnt = 0;
      bus.conv_done_i = 1'b0;
    end
    if (bus.z_rd_o) bus.z_rdata_i = zmem[bus.z_addr_o];
  end

  int cnt_wr, cnt_hs, cnt_done, cnt_esz, cnt_eto, cnt_zrd, cnt_start, cnt_sready, cnt_cmdlow, cnt_stall;
  logic prev_stall = 1'b0;
  logic [Z_W+1:0] prev_word;

  task automatic clear_counts();
    cnt_wr = 0; cnt_hs = 0; cnt_done = 0; cnt_esz = 0; cnt_eto = 0;
    cnt_zrd = 0; cnt_start = 0; cnt_sready = 0; cnt_cmdlow = 0; cnt_stall = 0;
    prev_stall = 1'b0;
  endtask

  // One clock: monitor on the falling edge, return just after the rising edge.
  task automatic tick();
    logic [ADDR_W+DATA_W:0] w_exp;
    logic [Z_W:0] z_exp;
    @(negedge clk);
    if (bus.mem_we_o) begin
      cnt_wr++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write_unexpected got sel=%0d addr=%0d data=%0d required none", bus.mem_sel_o, bus.mem_addr_o, bus.mem_wdata_o);
      end else begin
        w_exp = exp_wr_q.pop_front();
        if ({bus.mem_sel_o, bus.mem_addr_o, bus.mem_wdata_o} !== w_exp) begin
          errors++;
          $display("FAIL mem_write got %h required %h", {bus.mem_sel_o, bus.mem_addr_o, bus.mem_wdata_o}, w_exp);
        end
      end
    end
    if (bus.m_valid_o && bus.m_ready_i) begin
      cnt_hs++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL z_word_unexpected got data=%0d last=%0d required none", bus.m_data_o, bus.m_last_o);
      end else begin
        z_exp = exp_q.pop_front();
        if ({bus.m_last_o, bus.m_data_o} !== z_exp) begin
          errors++;
          $display("FAIL z_word got last=%0d data=%0d required last=%0d data=%0d", bus.m_last_o, bus.m_data_o, z_exp[Z_W], z_exp[Z_W-1:0]);
        end
      end
    end
    if (prev_stall) begin
      cnt_stall++;
      checks++;
      if ({bus.m_valid_o, bus.m_last_o, bus.m_data_o} !== prev_word) begin
        errors++;
        $display("FAIL stall_hold got %h required %h", {bus.m_valid_o, bus.m_last_o, bus.m_data_o}, prev_word);
      end
    end
    prev_stall = bus.m_valid_o && !bus.m_ready_i;
    prev_word  = {bus.m_valid_o, bus.m_last_o, bus.m_data_o};
    if (bus.job_done_o)    cnt_done++;
    if (bus.err_size_o)    cnt_esz++;
    if (bus.err_timeout_o) cnt_eto++;
    if (bus.z_rd_o)        cnt_zrd++;
    if (bus.conv_start_o)  cnt_start++;
    if (bus.s_ready_o)     cnt_sready++;
    if (!bus.cmd_ready_o)  cnt_cmdlow++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input bit with_z);
    int zl;
    for (int i = 0; i < sx; i++) exp_wr_q.push_back({1'b0, ADDR_W'(i), xv[i]});
    for (int i = 0; i < sy; i++) exp_wr_q.push_back({1'b1, ADDR_W'(i), yv[i]});
    if (with_z) begin
      zl = sx + sy - 1;
      for (int k = 0; k < zl; k++) begin
        int acc;
        acc = 0;
        for (int i = 0; i < sx; i++)
          if ((k - i) >= 0 && (k - i) < sy) acc += int'(xv[i]) * int'(yv[k-i]);
        exp_q.push_back({(k == zl - 1), Z_W'(acc)});
      end
    end
  endtask

  task automatic send_cmd(input int x, input int y);
    bus.cmd_size_x_i = (ADDR_W+1)'(x);
    bus.cmd_size_y_i = (ADDR_W+1)'(y);
    bus.cmd_valid_i  = 1'b1;
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL cmd_ready got %b required 1", bus.cmd_ready_o); end
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic stream(input bit gap);
    int idx = 0;
    int tot = sx + sy;
    bit hs;
    bit phase = 1'b0;
    for (int c = 0; c < 400 && idx < tot; c++) begin
      if (gap && phase) begin
        bus.s_valid_i = 1'b0;
      end else begin
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = (idx < sx) ? xv[idx] : yv[idx-sx];
      end
      phase = !phase;
      hs = bus.s_valid_i && bus.s_ready_o;
      tick();
      if (hs) idx++;
    end
    bus.s_valid_i = 1'b0;
    checks++;
    if (idx != tot) begin errors++; $display("FAIL sample_stream got %0d accepted required %0d", idx, tot); end
  endtask

  task automatic wait_end(input bit bp);
    int k = 0;
    while (k < 800 && cnt_done == 0 && cnt_eto == 0) begin
      bus.m_ready_i = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      tick();
      k++;
    end
    bus.m_ready_i = 1'b1;
    checks++;
    if (cnt_done == 0 && cnt_eto == 0) begin errors++; $display("FAIL job_end_wait got no end within %0d cycles required done or timeout", k); end
    tick();
    tick();
  endtask

  task automatic do_job(input int x, input int y, input int delay, input bit gap, input bit bp);
    sx = x; sy = y; done_delay = delay;
    clear_counts();
    push_expect(1'b1);
    send_cmd(x, y);
    stream(gap);
    wait_end(bp);
  endtask

  task automatic set_nominal();
    xv[0] = 8'd1; xv[1] = 8'd2; xv[2] = 8'd3;
    yv[0] = 8'd4; yv[1] = 8'd5;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b required 1", bus.cmd_ready_o); end
    checks++; if ({bus.s_ready_o, bus.conv_start_o, bus.m_valid_o, bus.z_rd_o, bus.mem_we_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b required 00000", {bus.s_ready_o, bus.conv_start_o, bus.m_valid_o, bus.z_rd_o, bus.mem_we_o}); end
    checks++; if ({bus.job_done_o, bus.err_size_o, bus.err_timeout_o, bus.m_last_o} !== 4'b0) begin errors++; $display("FAIL reset_status got %b required 0000", {bus.job_done_o, bus.err_size_o, bus.err_timeout_o, bus.m_last_o}); end
    checks++; if ({bus.conv_size_x_o, bus.conv_size_y_o, bus.m_data_o} !== '0) begin errors++; $display("FAIL reset_data got %h required 0", {bus.conv_size_x_o, bus.conv_size_y_o, bus.m_data_o}); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d required %0d", bus.dbg_state, IDLE); end
  endtask

  task automatic test_nominal();
    set_nominal();
    do_job(3, 2, 20 - 8, 1'b0, 1'b0);
    checks++; if (cnt_hs != 4) begin errors++; $display("FAIL nominal_words got %0d required 4", cnt_hs); end
    checks++; if (cnt_wr != 5) begin errors++; $display("FAIL nominal_writes got %0d required 5", cnt_wr); end
    checks++; if (cnt_zrd != 4) begin errors++; $display("FAIL nominal_zreads got %0d required 4", cnt_zrd); end
    checks++; if (cnt_start != 12) begin errors++; $display("FAIL nominal_start_cycles got %0d required 12", cnt_start); end
    checks++; if (cnt_done != 1 || cnt_eto != 0) begin errors++; $display("FAIL nominal_status got done=%0d timeout=%0d required 1 0", cnt_done, cnt_eto); end
    checks++; if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin errors++; $display("FAIL nominal_leftover got %0d/%0d required 0/0", exp_q.size(), exp_wr_q.size()); end
    checks++; if (bus.conv_size_x_o !== 6'd3 || bus.conv_size_y_o !== 6'd2) begin errors++; $display("FAIL nominal_sizes got %0d,%0d required 3,2", bus.conv_size_x_o, bus.conv_size_y_o); end
  endtask

  task automatic test_backpressure();
    set_nominal();
    do_job(3, 2, 12, 1'b0, 1'b1);
    checks++; if (cnt_hs != 4) begin errors++; $display("FAIL bp_words got %0d required 4", cnt_hs); end
    checks++; if (cnt_stall == 0) begin errors++; $display("FAIL bp_stalls got %0d required >0", cnt_stall); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    xv[0] = 8'd7; yv[0] = 8'd9;
    do_job(1, 1, 5, 1'b1, 1'b0);
    checks++; if (cnt_wr != 2) begin errors++; $display("FAIL gap_writes got %0d required 2", cnt_wr); end
    checks++; if (cnt_hs != 1 || cnt_done != 1) begin errors++; $display("FAIL gap_words got %0d done=%0d required 1 1", cnt_hs, cnt_done); end
  endtask

  task automatic test_size_err();
    clear_counts();
    send_cmd(0, 2);
    repeat (3) tick();
    send_cmd(2, 33);
    repeat (3) tick();
    checks++; if (cnt_esz != 2) begin errors++; $display("FAIL size_err_pulses got %0d required 2", cnt_esz); end
    checks++; if (cnt_sready != 0 || cnt_start != 0) begin errors++; $display("FAIL size_err_activity got sready=%0d start=%0d required 0 0", cnt_sready, cnt_start); end
    checks++; if (cnt_cmdlow != 0) begin errors++; $display("FAIL size_err_cmd_ready got %0d low cycles required 0", cnt_cmdlow); end
  endtask

  task automatic test_max_size();
    for (int i = 0; i < 32; i++) begin
      xv[i] = DATA_W'($urandom_range(255, 0));
      yv[i] = DATA_W'($urandom_range(255, 0));
    end
    do_job(32, 32, 10, 1'b0, 1'b0);
    checks++; if (cnt_hs != 63) begin errors++; $display("FAIL max_words got %0d required 63", cnt_hs); end
    checks++; if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin errors++; $display("FAIL max_leftover got %0d/%0d required 0/0", exp_q.size(), exp_wr_q.size()); end
  endtask

  task automatic test_timeout();
    set_nominal();
    sx = 3; sy = 2; done_delay = 0;
    clear_counts();
    push_expect(1'b0);
    send_cmd(3, 2);
    stream(1'b0);
    wait_end(1'b0);
    checks++; if (cnt_start != TO_CYC) begin errors++; $display("FAIL timeout_start_cycles got %0d required %0d", cnt_start, TO_CYC); end
    checks++; if (cnt_eto != 1 || cnt_done != 0) begin errors++; $display("FAIL timeout_status got timeout=%0d done=%0d required 1 0", cnt_eto, cnt_done); end
    checks++; if (cnt_zrd != 0) begin errors++; $display("FAIL timeout_zreads got %0d required 0", cnt_zrd); end
    checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL timeout_state got %0d required %0d", bus.dbg_state, IDLE); end
    do_job(3, 2, TO_CYC - 1, 1'b0, 1'b0);
    checks++; if (cnt_eto != 0 || cnt_hs != 4) begin errors++; $display("FAIL done15_status got timeout=%0d words=%0d required 0 4", cnt_eto, cnt_hs); end
    do_job(3, 2, TO_CYC, 1'b0, 1'b0);
    checks++; if (cnt_eto != 0 || cnt_hs != 4 || cnt_start != TO_CYC) begin errors++; $display("FAIL done16_status got timeout=%0d words=%0d start=%0d required 0 4 %0d", cnt_eto, cnt_hs, cnt_start, TO_CYC); end
  endtask

  task automatic test_reset_wait_done();
    set_nominal();
    sx = 3; sy = 2; done_delay = 0;
    clear_counts();
    push_expect(1'b0);
    send_cmd(3, 2);
    stream(1'b0);
    for (int c = 0; c < 100 && cnt_start < 5; c++) tick();
    checks++; if (cnt_start != 5) begin errors++; $display("FAIL rst_reach_wait got %0d start cycles required 5", cnt_start); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.conv_start_o !== 1'b0) begin errors++; $display("FAIL rst_async_start got %b required 0", bus.conv_start_o); end
    checks++; if (bus.cmd_ready_o !== 1'b1 || bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_async_idle got ready=%b valid=%b required 1 0", bus.cmd_ready_o, bus.m_valid_o); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.cmd_ready_o !== 1'b1 || bus.conv_size_x_o !== '0) begin errors++; $display("FAIL rst_after got ready=%b size_x=%0d required 1 0", bus.cmd_ready_o, bus.conv_size_x_o); end
    exp_q.delete();
    exp_wr_q.delete();
    do_job(3, 2, 12, 1'b0, 1'b0);
    checks++; if (cnt_hs != 4 || cnt_done != 1 || exp_q.size() != 0) begin errors++; $display("FAIL rst_rerun got words=%0d done=%0d left=%0d required 4 1 0", cnt_hs, cnt_done, exp_q.size()); end
  endtask

  initial begin
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_size_x_i = '0;
    bus.cmd_size_y_i = '0;
    bus.s_valid_i    = 1'b0;
    bus.s_data_i     = '0;
    bus.m_ready_i    = 1'b1;
    clear_counts();
    test_reset();
    test_nominal();
    test_backpressure();
    test_gaps();
    test_size_err();
    test_max_size();
    test_timeout();
    test_reset_wait_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog got no finish by 500000 required finish");
    $fatal(1);
  end

endmodule
